// File: rtl/fft_sample_loader.sv
// fft_sample_loader: gathers D_WIDTH complex samples into a bit-reversed frame buffer and launches the FFT engine.
// Latency: a write shows on output_Re/output_Im one cycle after its accept; start pulses the cycle after the last accept.
// Backpressure: in_ready is low in reset, LAUNCH and WAIT; the buffer is frozen until engine_done returns us to FILL.
//
// Ports:
//   clk, rst               - clock and synchronous active-high reset
//   in_valid/in_ready      - sample handshake; in_Re/in_Im carry the two's complement sample
//   engine_done            - one-cycle pulse from the butterfly engine, frame consumed
//   output_Re/output_Im    - frame buffer presented to the engine, bit-reversed order
//   start                  - one-cycle launch pulse (the single LAUNCH cycle)
//   frame_cnt              - frames launched, modulo 256
module fft_sample_loader #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_Re,
    input  logic [15:0] in_Im,
    input  logic        engine_done,
    output logic [15:0] output_Re [D_WIDTH],
    output logic [15:0] output_Im [D_WIDTH],
    output logic        start,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [LOG_2_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG_2_WIDTH-1:0] wr_addr;
    logic                   start_q, start_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]            re_q [D_WIDTH];
    logic [15:0]            im_q [D_WIDTH];
    logic                   accept;

    // Samples arrive in natural order; storing them at the bit-reversed
    // address hands the engine its decimation-in-time input ordering.
    function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] v);
        logic [LOG_2_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LOG_2_WIDTH; i++) begin
            r[i] = v[LOG_2_WIDTH-1-i];
        end
        return r;
    endfunction

    // Reset gates ready directly so nothing is accepted while rst is high.
    assign in_ready = (state_q == FILL) && !rst;
    assign accept   = in_valid && in_ready;
    assign wr_addr  = bitrev(wr_cnt_q);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    // Counter width equals log2(D_WIDTH), so it wraps to 0 here.
                    wr_cnt_d = wr_cnt_q + LOG_2_WIDTH'(1);
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d     = LAUNCH;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (engine_done) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        // start is registered and high exactly while the state register holds LAUNCH.
        start_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            start_q     <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < D_WIDTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            start_q     <= start_d;
            frame_cnt_q <= frame_cnt_d;
            // accept is only possible in FILL, so the buffer is frozen in LAUNCH/WAIT.
            if (accept) begin
                re_q[wr_addr] <= in_Re;
                im_q[wr_addr] <= in_Im;
            end
        end
    end

    assign output_Re = re_q;
    assign output_Im = im_q;
    assign start     = start_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
module tb_fft_sample_loader;

    localparam int D = 64;
    localparam int L = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_Re;
    logic [15:0] in_Im;
    logic        engine_done;
    logic [15:0] output_Re [D];
    logic [15:0] output_Im [D];
    logic        start;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    fft_sample_loader #(.D_WIDTH(D), .LOG_2_WIDTH(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_Re       (in_Re),
        .in_Im       (in_Im),
        .engine_done (engine_done),
        .output_Re   (output_Re),
        .output_Im   (output_Im),
        .start       (start),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        int          idx;
        logic [15:0] re;
        logic [15:0] im;
    } vec_t;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: 0 = FILL, 1 = LAUNCH, 2 = WAIT
    int          m_state = 0;
    int          m_wr = 0;
    int          m_frames = 0;
    logic [15:0] m_re [D];
    logic [15:0] m_im [D];
    vec_t        sb_q [$];
    vec_t        probes [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int rev(input int i);
        int r = 0;
        for (int b = 0; b < L; b++) if (i[b]) r = r | (1 << (L - 1 - b));
        return r;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_wr     = 0;
        m_frames = 0;
        for (int i = 0; i < D; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        sb_q.delete();
    endtask

    // One clock cycle: drive, check ready before the edge, update model, check after the edge.
    task automatic step(input logic r, input logic v, input logic [15:0] re,
                        input logic [15:0] im, input logic d);
        logic acc;
        vec_t e;
        rst = r; in_valid = v; in_Re = re; in_Im = im; engine_done = d;
        #1;
        check("in_ready", 32'(in_ready), 32'(!r && m_state == 0));
        acc = v && !r && (m_state == 0);
        if (r) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (acc) begin
                    e.idx = rev(m_wr); e.re = re; e.im = im;
                    sb_q.push_back(e);
                    m_re[e.idx] = re;
                    m_im[e.idx] = im;
                    if (m_wr == D - 1) begin
                        m_state  = 1;
                        m_frames = (m_frames + 1) % 256;
                    end
                    m_wr = (m_wr + 1) % D;
                end
                1: m_state = 2;
                default: if (d) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
        check("start", 32'(start), 32'(m_state == 1));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_re", 32'(output_Re[e.idx]), 32'(e.re));
            check("sb_im", 32'(output_Im[e.idx]), 32'(e.im));
        end
    endtask

    task automatic check_buf(input string name);
        int bad = -1;
        for (int i = 0; i < D; i++)
            if (bad < 0 && (output_Re[i] !== m_re[i] || output_Im[i] !== m_im[i])) bad = i;
        chk_cnt++;
        if (bad < 0) pass_cnt++;
        else $display("FAIL %s: entry %0d got %h/%h expected %h/%h", name, bad,
                      output_Re[bad], output_Im[bad], m_re[bad], m_im[bad]);
    endtask

    task automatic check_probes(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_re[%0d]", tag, probes[i].idx), 32'(output_Re[probes[i].idx]), 32'(probes[i].re));
            check($sformatf("%s_im[%0d]", tag, probes[i].idx), 32'(output_Im[probes[i].idx]), 32'(probes[i].im));
        end
    endtask

    initial begin
        // Expected frame contents for in_Re=k, in_Im=-k, derived by hand.
        probes[0] = '{0,  16'h0000, 16'h0000};
        probes[1] = '{32, 16'h0001, 16'hFFFF};
        probes[2] = '{1,  16'h0020, 16'hFFE0};
        probes[3] = '{63, 16'h003F, 16'hFFC1};
        probes[4] = '{16, 16'h0002, 16'hFFFE};
        probes[5] = '{31, 16'h003E, 16'hFFC2};
        model_reset();

        // Reset for two cycles, with valid and done asserted to show reset priority.
        step(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b1);
        step(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b1);
        check_buf("reset_buf");
        check("reset_start", 32'(start), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);

        // Continuous fill.
        for (int k = 0; k < D; k++) step(1'b0, 1'b1, 16'(k), 16'(-k), 1'b0);
        check("cont_start", 32'(start), 32'd1);
        check("cont_frame_cnt", 32'(frame_cnt), 32'd1);
        check_probes("cont");

        // Back-pressure: valid held with changing data, done 20 cycles after start.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0);
        step(1'b0, 1'b1, 16'h0300, 16'h0400, 1'b1);
        check_probes("bp_hold");
        check_buf("bp_buf");
        step(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0);
        check("bp_next_re0", 32'(output_Re[0]), 32'h1234);
        check("bp_next_im0", 32'(output_Im[0]), 32'h5678);

        // Reset mid-fill after 10 accepts; engine_done in FILL is ignored.
        for (int k = 1; k < 10; k++) step(1'b0, 1'b1, 16'(k * 3), 16'(k * 5), 1'b1);
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        check_buf("midrst_buf");
        check("midrst_re0", 32'(output_Re[0]), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);

        // Gapped fill after the reset: needs a full 64 accepts; done in LAUNCH ignored.
        for (int k = 0; k < D; k++) begin
            step(1'b0, 1'b1, 16'(k), 16'(-k), 1'b0);
            if (k == D - 1) check("gap_start", 32'(start), 32'd1);
            step(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, k == D - 1);
        end
        check_probes("gap");
        check("gap_frame_cnt", 32'(frame_cnt), 32'd1);
        step(1'b0, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0);
        step(1'b0, 1'b1, 16'h0F0F, 16'h0F0F, 1'b1);
        check_buf("gap_wait_buf");

        // Frame counter wrap over 257 frames with immediate engine_done.
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int f = 1; f <= 257; f++) begin
            for (int k = 0; k < D; k++) step(1'b0, 1'b1, 16'(f + k), 16'(f - k), 1'b0);
            if (f == 256) check("wrap_256", 32'(frame_cnt), 32'd0);
            if (f == 257) check("wrap_257", 32'(frame_cnt), 32'd1);
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        end
        check_buf("wrap_buf");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
